dac_spi_master: RTL



---
 rtl/dac_spi_master.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dac_spi_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dac_spi_master : SPI mode-0 shift engine driving the DAC serial pins        |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module dac_spi_master #(
  parameter int DATA_W  = 24,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              dac_clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              dac_sck_o,
  output logic              dac_cs_n_o,
  output logic              dac_mosi_o,
  input  logic              dac_miso_i
);

  localparam int MAX_A = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int MAX_V = (MAX_A > DATA_W) ? MAX_A : DATA_W;
  localparam int CNT_W = $clog2(MAX_V + 1);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0] tx_sh, tx_sh_d;
  logic [DATA_W-1:0] rx_sh, rx_sh_d;
  logic [DATA_W-1:0] rx_data_d;
  logic              tx_ready_d, busy_d, rx_valid_d;
  logic              sck_d, cs_n_d, mosi_d;
  logic              div_done;

  always_ff @(posedge dac_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data    <= '0;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      rx_valid   <= 1'b0;
      dac_sck_o  <= 1'b0;
      dac_cs_n_o <= 1'b1;
      dac_mosi_o <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_cnt    <= bit_cnt_d;
      tx_sh      <= tx_sh_d;
      rx_sh      <= rx_sh_d;
      rx_data    <= rx_data_d;
      tx_ready   <= tx_ready_d;
      busy       <= busy_d;
      rx_valid   <= rx_valid_d;
      dac_sck_o  <= sck_d;
      dac_cs_n_o <= cs_n_d;
      dac_mosi_o <= mosi_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    bit_cnt_d  = bit_cnt;
    tx_sh_d    = tx_sh;
    rx_sh_d    = rx_sh;
    rx_data_d  = rx_data;
    tx_ready_d = tx_ready;
    busy_d     = busy;
    rx_valid_d = 1'b0;
    sck_d      = dac_sck_o;
    cs_n_d     = dac_cs_n_o;
    mosi_d     = dac_mosi_o;
    div_done   = (cnt == DIV_LAST);

    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d    = SETUP;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          tx_sh_d    = tx_data << 1;
          rx_sh_d    = '0;
          mosi_d     = tx_data[DATA_W-1];
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          tx_ready_d = 1'b0;
        end
      end
      SETUP: begin
        if (div_done) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      SHIFT: begin
        if (div_done) begin
          cnt_d = '0;
          sck_d = ~dac_sck_o;
          // Falling edge closes the high phase: capture MISO, then launch the next MOSI bit.
          if (dac_sck_o) begin
            rx_sh_d = {rx_sh[DATA_W-2:0], dac_miso_i};
            if (bit_cnt == BIT_LAST) begin
              state_d = HOLD;
            end else begin
              bit_cnt_d = bit_cnt + CNT_ONE;
              mosi_d    = tx_sh[DATA_W-1];
              tx_sh_d   = tx_sh << 1;
            end
          end
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      HOLD: begin
        if (div_done) begin
          cnt_d      = '0;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sh;
          rx_valid_d = 1'b1;
          state_d    = GAP;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d      = '0;
          busy_d     = 1'b0;
          tx_ready_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
